uart_boot_loader: RTL

- Serial program loader upstream of the CPU top level.
- Receives a framed image over a UART RX pin and writes it byte-by-byte into test memory through the memory write port (split low/high address bytes).
- Holds the CPU in reset until the image is complete, then releases it.
- Lets the 6502 core run new programs without re-synthesising the memory image.

---
 rtl/uart_boot_loader.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART image loader that writes memory and holds the CPU; `define BOOT_CHECKSUM_EN adds a trailing sum byte
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] mem_addr_l,
    output logic [7:0] mem_addr_h,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // Presetting to 1 keeps the line looking idle so reset never fakes a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t         rx_state, rx_state_n;
    logic [CW-1:0]     clk_cnt, clk_cnt_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift_q, shift_n;
    logic              byte_valid, byte_valid_n;
    logic              frame_err, frame_err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            clk_cnt    <= clk_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_q    <= shift_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        clk_cnt_n    = clk_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift_q;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (!rx_s) begin
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                // Mid-start resample rejects pulses shorter than half a bit.
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_n  = '0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift_q[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n  = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_s) begin
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    typedef enum logic [2:0] {
        LD_ADDR_L,
        LD_ADDR_H,
        LD_LEN_L,
        LD_LEN_H,
        LD_DATA,
`ifdef BOOT_CHECKSUM_EN
        LD_CHK,
`endif
        LD_DONE,
        LD_ERR
    } ld_state_t;

    ld_state_t   ld_state, ld_state_n;
    logic [15:0] ptr, ptr_n;
    logic [15:0] remaining, remaining_n;
    logic [15:0] mem_addr_n;
    logic [7:0]  mem_wdata_n;
    logic        mem_we_n;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  sum_q, sum_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state   <= LD_ADDR_L;
            ptr        <= '0;
            remaining  <= '0;
            mem_addr_l <= '0;
            mem_addr_h <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            ld_state   <= ld_state_n;
            ptr        <= ptr_n;
            remaining  <= remaining_n;
            mem_addr_l <= mem_addr_n[7:0];
            mem_addr_h <= mem_addr_n[15:8];
            mem_wdata  <= mem_wdata_n;
            mem_we     <= mem_we_n;
            // Status trails the state by one cycle so release follows the last strobe.
            cpu_hold   <= (ld_state != LD_DONE);
            load_done  <= (ld_state == LD_DONE);
            load_err   <= (ld_state == LD_ERR);
`ifdef BOOT_CHECKSUM_EN
            sum_q      <= sum_n;
`endif
        end
    end

    always_comb begin
        ld_state_n  = ld_state;
        ptr_n       = ptr;
        remaining_n = remaining;
        mem_addr_n  = {mem_addr_h, mem_addr_l};
        mem_wdata_n = mem_wdata;
        mem_we_n    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_n       = sum_q;
`endif
        if (frame_err && ld_state != LD_DONE && ld_state != LD_ERR) begin
            ld_state_n = LD_ERR;
        end else if (byte_valid) begin
            case (ld_state)
                LD_ADDR_L: begin
                    ptr_n[7:0] = shift_q;
                    ld_state_n = LD_ADDR_H;
                end
                LD_ADDR_H: begin
                    ptr_n[15:8] = shift_q;
                    ld_state_n  = LD_LEN_L;
                end
                LD_LEN_L: begin
                    remaining_n[7:0] = shift_q;
                    ld_state_n       = LD_LEN_H;
                end
                LD_LEN_H: begin
                    remaining_n[15:8] = shift_q;
                    if ({shift_q, remaining[7:0]} == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        ld_state_n = LD_CHK;
`else
                        ld_state_n = LD_DONE;
`endif
                    end else begin
                        ld_state_n = LD_DATA;
                    end
                end
                LD_DATA: begin
                    mem_we_n    = 1'b1;
                    mem_wdata_n = shift_q;
                    mem_addr_n  = ptr;
                    ptr_n       = ptr + 16'd1;
                    remaining_n = remaining - 16'd1;
`ifdef BOOT_CHECKSUM_EN
                    sum_n       = sum_q + shift_q;
`endif
                    if (remaining == 16'd1) begin
`ifdef BOOT_CHECKSUM_EN
                        ld_state_n = LD_CHK;
`else
                        ld_state_n = LD_DONE;
`endif
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                LD_CHK: begin
                    ld_state_n = (shift_q == sum_q) ? LD_DONE : LD_ERR;
                end
`endif
                default: ld_state_n = ld_state;
            endcase
        end
    end

endmodule
